// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FWFT valid/ready FIFO controller in front of a simple dual-port RAM with 1-cycle registered read
// Ports:
//   clk, rst                    single clock (also the RAM's wclk/rclk), synchronous active-high reset
//   in_data/in_valid/in_ready   write stream; a push writes the RAM in the same cycle
//   out_data/out_valid/out_ready first-word-fall-through read stream
//   ram_din/ram_write_en/ram_waddr  RAM write port
//   ram_raddr/ram_dout          RAM read port; ram_dout is valid the cycle after ram_raddr is sampled
//   level                       total entries held (RAM + inflight + output buffer); only with RAM_FIFO_LEVEL_EN
// Optional feature: define RAM_FIFO_LEVEL_EN to add the level output and its adder.
module ram_fifo_ctrl #(
    parameter int addr_width = 8,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] ram_din,
    output logic                  ram_write_en,
    output logic [addr_width-1:0] ram_waddr,
    output logic [addr_width-1:0] ram_raddr,
    input  logic [data_width-1:0] ram_dout
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output logic [addr_width+1:0] level
`endif
);
    logic [addr_width:0]   wptr, rptr, ram_cnt;
    logic [data_width-1:0] head, skid;
    logic [1:0]            buf_cnt, occ;
    logic                  inflight, push, pop, issue, empty_ap;
    // buf_cnt + inflight never exceeds 2, so occ (slots committed after this pop) fits in 2 bits
    always_comb begin
        ram_cnt   = wptr - rptr;
        in_ready  = !ram_cnt[addr_width] && !rst;
        push      = in_valid && in_ready;
        out_valid = buf_cnt != 2'd0;
        pop       = out_valid && out_ready;
        occ       = buf_cnt + {1'b0, inflight} - {1'b0, pop};
        issue     = (ram_cnt != '0) && !occ[1];
        empty_ap  = (buf_cnt - {1'b0, pop}) == 2'd0;
    end
    assign out_data     = head;
    assign ram_din      = in_data;
    assign ram_write_en = push;
    assign ram_waddr    = wptr[addr_width-1:0];
    assign ram_raddr    = rptr[addr_width-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            buf_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            wptr     <= wptr + (addr_width+1)'(push);
            rptr     <= rptr + (addr_width+1)'(issue);
            inflight <= issue;
            buf_cnt  <= occ;
        end
    end
    // Payload registers need no reset: buf_cnt alone decides what is valid
    always_ff @(posedge clk) begin
        if (inflight && empty_ap)
            head <= ram_dout;
        else if (pop && buf_cnt == 2'd2)
            head <= skid;
        if (inflight && !empty_ap)
            skid <= ram_dout;
    end
`ifdef RAM_FIFO_LEVEL_EN
    assign level = {1'b0, ram_cnt} + (addr_width+2)'(inflight) + (addr_width+2)'(buf_cnt);
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: randomized self-checking bench for ram_fifo_ctrl against a queue-based reference model
module tb_ram_fifo_ctrl;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] ram_din;
    logic          ram_write_en;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;
`ifdef RAM_FIFO_LEVEL_EN
    logic [AW+1:0] level;
`endif

    ram_fifo_ctrl #(.addr_width(AW), .data_width(DW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_din(ram_din), .ram_write_en(ram_write_en),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
`ifdef RAM_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_waddr] <= ram_din;
        ram_dout <= mem[ram_raddr];
    end

    int vectors = 0, errs = 0, cyc = 0;
    int n_ram = 0, n_push = 0, n_iss = 0, acc = 0;
    int p_q[$];
    logic [DW-1:0] d_q[$];
    bit m_push, m_pop, m_issue, e_valid, e_ready;
    logic [DW-1:0] nxt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model: entries accepted but not yet read sit in the RAM; an issued entry is
    // presentable two cycles after its issue; at most two entries issued and unpopped.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            chk("in_ready_rst", {31'b0, in_ready}, 0);
            chk("wen_rst", {31'b0, ram_write_en}, 0);
            m_push = 0; m_pop = 0; m_issue = 0;
        end else begin
            e_valid = p_q.size() > 0 && p_q[0] <= cyc - 2;
            e_ready = n_ram < DEPTH;
            m_push  = in_valid && e_ready;
            m_pop   = e_valid && out_ready;
            m_issue = n_ram > 0 && (p_q.size() - int'(m_pop)) < 2;
            chk("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
            chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
            chk("ram_write_en", {31'b0, ram_write_en}, {31'b0, m_push});
            if (e_valid) chk("out_data", {24'b0, out_data}, {24'b0, d_q[0]});
            if (m_push) chk("ram_waddr", {29'b0, ram_waddr}, n_push % DEPTH);
            if (m_issue) chk("ram_raddr", {29'b0, ram_raddr}, n_iss % DEPTH);
`ifdef RAM_FIFO_LEVEL_EN
            chk("level", {27'b0, level}, n_ram + p_q.size());
`endif
        end
        @(posedge clk);
        #1;
        if (rst) begin
            d_q.delete(); p_q.delete();
            n_ram = 0; n_push = 0; n_iss = 0;
        end else begin
            if (m_push) begin d_q.push_back(in_data); n_ram++; n_push++; end
            if (m_issue) begin n_ram--; p_q.push_back(cyc); n_iss++; end
            if (m_pop) begin void'(d_q.pop_front()); void'(p_q.pop_front()); end
        end
        cyc++;
    endtask

    task automatic cyc1(input bit v, input bit r);
        in_valid = v;
        out_ready = r;
        in_data = nxt;
        step();
        if (m_push) begin nxt++; acc++; end
    endtask

    initial begin
        rst = 1'b1;
        cyc1(1, 1);
        cyc1(1, 1);
        rst = 1'b0;
        // single word latency
        nxt = 8'hA5;
        cyc1(1, 1);
        repeat (6) cyc1(0, 1);
        // fill past capacity, then drain
        nxt = 8'h00;
        repeat (16) cyc1(1, 0);
        repeat (14) cyc1(0, 1);
        // streaming
        acc = 0;
        for (int i = 0; i < 200 && acc < 100; i++) cyc1(1, 1);
        chk("stream_done", acc, 100);
        repeat (6) cyc1(0, 1);
        // random backpressure and valid gaps across many pointer wraps
        nxt = 8'h00;
        acc = 0;
        for (int i = 0; i < 5000 && acc < 256; i++)
            cyc1($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
        chk("bp_done", acc, 256);
        repeat (12) cyc1(0, 1);
        // reset with entries held and a read inflight
        repeat (6) cyc1(1, 0);
        repeat (2) cyc1(0, 0);
        cyc1(0, 1);
        rst = 1'b1;
        cyc1(0, 0);
        rst = 1'b0;
        cyc1(0, 0);
        nxt = 8'h3C;
        cyc1(1, 1);
        repeat (6) cyc1(0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
